// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the write-port arbitration helper for the
// multi-port register file with scoreboard.
package regfile_pkg;

   // Top-level sequencing: sweep-clear every register, then normal operation.
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   // Default geometry of the register file.
   localparam int RF_DATA_WIDTH    = 32;
   localparam int RF_ADDRESS_WIDTH = 5;
   localparam int RF_NUM_REGS      = 32;
   localparam int RF_NUM_RD        = 2;
   localparam int RF_NUM_WR        = 2;

   // Upper bounds for the arbitration helper; ports and addresses are
   // zero-extended up to these sizes before calling win_port().
   localparam int MAX_PORTS  = 16;
   localparam int MAX_AW     = 16;
   localparam int PORT_IDX_W = 4;

   // Result of write-port arbitration for one address.
   typedef struct packed {
      logic                  hit;
      logic [PORT_IDX_W-1:0] port;
   } win_t;

   // Highest-index enabled port whose destination equals addr.
   function automatic win_t win_port(
      input logic [MAX_PORTS-1:0]             en,
      input logic [MAX_PORTS-1:0][MAX_AW-1:0] dest,
      input logic [MAX_AW-1:0]                addr
   );
      win_t w;
      w = '0;
      for (int k = 0; k < MAX_PORTS; k++) begin
         if (en[k] && (dest[k] == addr)) begin
            w.hit  = 1'b1;
            w.port = PORT_IDX_W'(k);
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx from 0 to NUM_REGS-1, one
// register per cycle, then parks in RUN until the next reset.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int CLR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic             init_busy,
   output logic             clr_we,
   output logic [CLR_W-1:0] clr_addr
);

   localparam logic [CLR_W-1:0] LAST_IDX = CLR_W'(NUM_REGS - 1);

   rf_state_t        state_q, state_d;
   logic [CLR_W-1:0] clr_idx_q, clr_idx_d;

   // State and index registers; reset restarts the sweep from r0.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RF_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Advance one register per cycle while clearing; stop on the last one.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we    = 1'b0;
      unique case (state_q)
         RF_CLEAR: begin
            clr_we = ~rst;
            if (clr_idx_q == LAST_IDX) begin
               state_d = RF_RUN;
            end else begin
               clr_idx_d = clr_idx_q + CLR_W'(1);
            end
         end
         RF_RUN: begin
            state_d = RF_RUN;
         end
      endcase
   end

   assign clr_addr  = clr_idx_q;
   assign init_busy = rst | (state_q == RF_CLEAR);

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with optional hardwired r0, same-cycle write
// bypass and a pending-write scoreboard. Decode reads and sets pending bits,
// writeback writes and clears them.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH    = RF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
   parameter int NUM_REGS      = RF_NUM_REGS,
   parameter int NUM_RD        = RF_NUM_RD,
   parameter int NUM_WR        = RF_NUM_WR,
   parameter int ZERO_REG0     = 1,
   parameter int BYPASS        = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_WR-1:0]                 wr_en,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   wr_dest,
   input  logic [NUM_WR*DATA_WIDTH-1:0]      wr_data,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]      rd_data,
   output logic [NUM_RD-1:0]                 rd_pending,
   input  logic                              sb_set_en,
   input  logic [ADDRESS_WIDTH-1:0]          sb_set_dest,
   output logic [NUM_REGS-1:0]               pending,
   output logic                              init_busy
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int CLR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // Reject geometries the addressing and arbitration cannot represent.
   if (NUM_REGS > (2 ** ADDRESS_WIDTH)) begin : g_bad_num_regs
      $error("regfile_mp_sb: NUM_REGS exceeds 2**ADDRESS_WIDTH");
   end
   if (NUM_RD < 1) begin : g_bad_num_rd
      $error("regfile_mp_sb: NUM_RD must be at least 1");
   end
   if ((NUM_WR < 1) || (NUM_WR > MAX_PORTS)) begin : g_bad_num_wr
      $error("regfile_mp_sb: NUM_WR out of range");
   end
   if (ADDRESS_WIDTH > MAX_AW) begin : g_bad_aw
      $error("regfile_mp_sb: ADDRESS_WIDTH too large");
   end

   logic             busy;
   logic             clr_we;
   logic [CLR_W-1:0] clr_addr;

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .CLR_W    (CLR_W)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .init_busy (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign init_busy = busy;

   logic [DW-1:0]                    reg_q [NUM_REGS];
   logic [DW-1:0]                    wdata [NUM_WR];
   logic [MAX_PORTS-1:0]             acc_en;
   logic [MAX_PORTS-1:0][MAX_AW-1:0] acc_dest;
   logic [NUM_REGS-1:0]              reg_we;
   logic [DW-1:0]                    reg_wdata [NUM_REGS];
   logic [NUM_REGS-1:0]              pending_q, pending_d;
   logic                             sb_ok;

   for (genvar k = 0; k < NUM_WR; k++) begin : g_wdata
      assign wdata[k] = wr_data[k*DW +: DW];
   end

   // True for an address that names a writable, implemented register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (int'(a) < NUM_REGS) && !((ZERO_REG0 != 0) && (a == '0));
   endfunction

   // Data carried by the winning write port.
   function automatic logic [DW-1:0] port_data(input win_t w);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (int'(w.port) == k) d = wdata[k];
      end
      return d;
   endfunction

   // Qualify write ports: RUN only, implemented register, never r0 when hardwired.
   always_comb begin
      acc_en   = '0;
      acc_dest = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         acc_en[k]   = wr_en[k] & ~busy & addr_ok(wr_dest[k*AW +: AW]);
         acc_dest[k] = MAX_AW'(wr_dest[k*AW +: AW]);
      end
   end

   // Resolve the write landing in each register; the highest port wins.
   always_comb begin
      win_t w;
      w         = '0;
      reg_we    = '0;
      reg_wdata = '{default: '0};
      for (int r = 0; r < NUM_REGS; r++) begin
         w            = win_port(acc_en, acc_dest, MAX_AW'(r));
         reg_we[r]    = w.hit;
         reg_wdata[r] = port_data(w);
      end
   end

   // Register storage: clear-sequencer writes first, then accepted writes.
   // NOTE: the array has no reset branch; the clear sequencer zeroes it one
   // entry per cycle, so the storage stays a plain enable-only flop array.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (clr_we && (clr_addr == CLR_W'(r))) begin
            reg_q[r] <= '0;
         end else if (reg_we[r]) begin
            reg_q[r] <= reg_wdata[r];
         end
      end
   end

   // Next pending bits: writes clear, issue sets, set beats a same-cycle clear.
   always_comb begin
      pending_d = pending_q;
      sb_ok     = sb_set_en & ~busy & addr_ok(sb_set_dest);
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_d[r] = pending_q[r] & ~reg_we[r];
         if (sb_ok && (sb_set_dest == AW'(r))) pending_d[r] = 1'b1;
      end
   end

   // Scoreboard flops; reset empties the scoreboard in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

   // Read ports: zero while busy or for r0/unimplemented, else bypass or array.
   always_comb begin
      logic [AW-1:0] ra;
      win_t          w;
      logic          byp;
      ra         = '0;
      w          = '0;
      byp        = 1'b0;
      rd_data    = '0;
      rd_pending = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         ra  = rd_addr[j*AW +: AW];
         w   = win_port(acc_en, acc_dest, MAX_AW'(ra));
         byp = (BYPASS != 0) && w.hit;
         if (!busy && addr_ok(ra)) begin
            rd_data[j*DW +: DW] = byp ? port_data(w) : reg_q[CLR_W'(ra)];
            rd_pending[j]       = pending_q[CLR_W'(ra)] & ~byp;
         end
      end
   end

endmodule
